// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - shared SHA constants, scan FSM states and summary-word layout
package sha_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SCAN,
    S_WR_SUM,
    S_WR_BEST
  } state_e;

  localparam int NUM_NONCES_DEF = 16;

  localparam int SUM_FOUND_BIT = 31;
  localparam int SUM_COUNT_LSB = 16;
  localparam int SUM_FIRST_LSB = 8;
  localparam int SUM_BEST_LSB  = 0;

  localparam logic [31:0] SHA256_H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] pack_summary(input logic       found,
                                               input logic [4:0] cnt,
                                               input logic [3:0] first,
                                               input logic [3:0] best);
    logic [31:0] w;
    w = '0;
    w[SUM_FOUND_BIT]        = found;
    w[SUM_COUNT_LSB +: 5]   = cnt;
    w[SUM_FIRST_LSB +: 4]   = first;
    w[SUM_BEST_LSB  +: 4]   = best;
    return w;
  endfunction

endpackage

// File: rtl/hash_target_check.sv
// rtl/hash_target_check.sv - scans NUM_NONCES H0 words against a target, writes summary and best hash
module hash_target_check
  import sha_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] hash_in_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] memory_addr,
  output logic [31:0] memory_write_data,
  input  logic [31:0] memory_read_data
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_NONCES - 1);

  state_e      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [15:0] res_q, res_d;
  logic [31:0] target_q, target_d;
  logic [3:0]  idx_q, idx_d;
  logic        found_q, found_d;
  logic [4:0]  count_q, count_d;
  logic [3:0]  first_q, first_d;
  logic [31:0] best_hash_q, best_hash_d;
  logic [3:0]  best_nonce_q, best_nonce_d;

  assign mem_clk = clk;
  assign done    = (state_q == S_IDLE);

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    res_d        = res_q;
    target_d     = target_q;
    idx_d        = idx_q;
    found_d      = found_q;
    count_d      = count_q;
    first_d      = first_q;
    best_hash_d  = best_hash_q;
    best_nonce_d = best_nonce_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d       = hash_in_addr;
          res_d        = result_addr;
          target_d     = target;
          idx_d        = '0;
          found_d      = 1'b0;
          count_d      = '0;
          first_d      = '0;
          best_hash_d  = '0;
          best_nonce_d = '0;
          state_d      = S_FETCH;
        end
      end
      S_FETCH: state_d = S_SCAN;
      S_SCAN: begin
        if (memory_read_data < target_q) begin
          count_d = count_q + 5'd1;
          found_d = 1'b1;
          if (!found_q) first_d = idx_q;
        end
        // Strict less-than keeps the lower index on ties; word 0 always seeds the minimum.
        if (idx_q == 4'd0 || memory_read_data < best_hash_q) begin
          best_hash_d  = memory_read_data;
          best_nonce_d = idx_q;
        end
        if (idx_q == LAST_IDX) state_d = S_WR_SUM;
        else                   idx_d   = idx_q + 4'd1;
      end
      S_WR_SUM:  state_d = S_WR_BEST;
      S_WR_BEST: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_we            = 1'b0;
    memory_addr       = '0;
    memory_write_data = '0;
    case (state_q)
      S_FETCH: memory_addr = base_q;
      S_SCAN:  memory_addr = base_q + {12'd0, idx_q} + 16'd1;
      S_WR_SUM: begin
        mem_we            = 1'b1;
        memory_addr       = res_q;
        memory_write_data = pack_summary(found_q, count_q, first_q, best_nonce_q);
      end
      S_WR_BEST: begin
        mem_we            = 1'b1;
        memory_addr       = res_q + 16'd1;
        memory_write_data = best_hash_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      res_q        <= '0;
      target_q     <= '0;
      idx_q        <= '0;
      found_q      <= 1'b0;
      count_q      <= '0;
      first_q      <= '0;
      best_hash_q  <= '0;
      best_nonce_q <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      res_q        <= res_d;
      target_q     <= target_d;
      idx_q        <= idx_d;
      found_q      <= found_d;
      count_q      <= count_d;
      first_q      <= first_d;
      best_hash_q  <= best_hash_d;
      best_nonce_q <= best_nonce_d;
    end
  end

endmodule

// File: tb/tb_hash_target_check.sv
// tb/tb_hash_target_check.sv - directed bench for hash_target_check with a reference scan model
module tb_hash_target_check;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start16 = 1'b0, start4 = 1'b0;
  logic [15:0] hash_in_addr = '0, result_addr = '0;
  logic [31:0] target = '0;
  logic        done16, done4, mem_clk16, mem_clk4, we16, we4;
  logic [15:0] addr16, addr4;
  logic [31:0] wd16, wd4;
  logic [31:0] rd16 = '0, rd4 = '0;

  logic [31:0] mem [0:65535];

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t         exp_q[$];
  logic [31:0] wr_log[$];
  logic [15:0] addr_log[$];
  bit          log_en = 1'b0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  hash_target_check #(.NUM_NONCES(16)) u16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .hash_in_addr(hash_in_addr),
    .result_addr(result_addr), .target(target), .done(done16), .mem_clk(mem_clk16),
    .mem_we(we16), .memory_addr(addr16), .memory_write_data(wd16), .memory_read_data(rd16)
  );

  hash_target_check #(.NUM_NONCES(4)) u4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .hash_in_addr(hash_in_addr),
    .result_addr(result_addr), .target(target), .done(done4), .mem_clk(mem_clk4),
    .mem_we(we4), .memory_addr(addr4), .memory_write_data(wd4), .memory_read_data(rd4)
  );

  always @(posedge clk) begin
    rd16 <= mem[addr16];
    rd4  <= mem[addr4];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every write the DUTs make must be the next one the model predicted.
  always @(negedge clk) begin
    wr_t e;
    if (we16 || we4) begin
      wr_log.push_back(we16 ? wd16 : wd4);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 we16 ? addr16 : addr4, we16 ? wd16 : wd4);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {16'd0, we16 ? addr16 : addr4}, {16'd0, e.a});
        chk("wr_data", we16 ? wd16 : wd4, e.d);
      end
    end
    if (log_en && !done4 && !we4) addr_log.push_back(addr4);
  end

  function automatic void model(input logic [31:0] w[16], input int n, input logic [31:0] t,
                                output logic [31:0] s, output logic [31:0] b);
    int cnt = 0;
    int first = -1;
    int bi = 0;
    logic [31:0] bv = w[0];
    for (int i = 0; i < n; i++) begin
      if (w[i] < t) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (w[i] < bv) begin
        bv = w[i];
        bi = i;
      end
    end
    s = (cnt > 0) ? 32'h8000_0000 : 32'h0;
    s = s | (32'(cnt) << 16) | (32'(bi) & 32'hF);
    if (first >= 0) s = s | (32'(first) << 8);
    b = bv;
  endfunction

  task automatic run_scan(input string tag, input bit use4, input logic [15:0] base,
                          input logic [15:0] res, input logic [31:0] tgt,
                          input logic [31:0] w[16], input int n, input bit poke,
                          input logic [31:0] lit_sum, input logic [31:0] lit_best);
    logic [31:0] s, b;
    int cyc;
    model(w, n, tgt, s, b);
    exp_q.push_back('{a: res, d: s});
    exp_q.push_back('{a: 16'(res + 16'd1), d: b});
    for (int i = 0; i < n; i++) mem[16'(base + 16'(i))] = w[i];
    wr_log = {};
    @(negedge clk);
    hash_in_addr = base;
    result_addr  = res;
    target       = tgt;
    if (use4) start4 = 1'b1; else start16 = 1'b1;
    @(posedge clk);
    #1;
    start4  = 1'b0;
    start16 = 1'b0;
    hash_in_addr = 16'h7777;
    result_addr  = 16'h7777;
    target       = 32'hFFFF_FFFF;
    cyc = 1;
    while (!(use4 ? done4 : done16) && cyc < 200) begin
      if (poke) start4 = (cyc == 3);
      @(posedge clk);
      #1;
      cyc++;
    end
    start4 = 1'b0;
    @(negedge clk);
    chk({tag, "_latency"}, 32'(cyc), 32'(n + 4));
    chk({tag, "_write_count"}, 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk({tag, "_summary"}, wr_log[0], lit_sum);
      chk({tag, "_best_hash"}, wr_log[1], lit_best);
    end
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    exp_q = {};
  endtask

  initial begin
    logic [31:0] w1 [16];
    logic [31:0] w [16];

    // Word 0 held large so only the tail words fall under the target.
    w1[0] = 32'hFFFF_0000;
    for (int i = 1; i < 16; i++) w1[i] = 32'(16 - i) << 28;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_done16", {31'd0, done16}, 32'd1);
    chk("rst_we16", {31'd0, we16}, 32'd0);
    chk("rst_addr16", {16'd0, addr16}, 32'd0);
    chk("rst_wdata16", wd16, 32'd0);
    chk("rst_done4", {31'd0, done4}, 32'd1);
    chk("rst_we4", {31'd0, we4}, 32'd0);
    @(negedge clk);
    chk("mem_clk", {31'd0, mem_clk16}, {31'd0, clk});
    reset_n = 1'b1;

    run_scan("descending", 1'b0, 16'h1000, 16'h4000, 32'h3000_0000, w1, 16, 1'b0,
             32'h8002_0E0F, 32'h1000_0000);

    for (int i = 0; i < 16; i++) w[i] = 32'hA000_0000 + (32'(i) << 24);
    w[9]  = 32'h0000_1234;
    w[12] = 32'h0000_1234;
    run_scan("target_zero", 1'b0, 16'h2000, 16'h4010, 32'h0, w, 16, 1'b0,
             32'h0000_0009, 32'h0000_1234);

    for (int i = 0; i < 16; i++) w[i] = 32'h5555_5555;
    run_scan("all_equal", 1'b0, 16'h3000, 16'h4020, 32'h5555_5556, w, 16, 1'b0,
             32'h8010_0000, 32'h5555_5555);

    for (int i = 0; i < 16; i++) w[i] = 32'hFFFF_FFF0 + 32'(i);
    run_scan("target_max", 1'b0, 16'h3100, 16'h4030, 32'hFFFF_FFFF, w, 16, 1'b0,
             32'h800F_0000, 32'hFFFF_FFF0);

    for (int i = 0; i < 16; i++) w[i] = 32'h0;
    w[0] = 32'h7;
    w[1] = 32'h3;
    w[2] = 32'hFFFF_FFFF;
    w[3] = 32'h3;
    addr_log = {};
    log_en = 1'b1;
    run_scan("wrap_n4", 1'b1, 16'hFFFE, 16'h4040, 32'hFFFF_FFFF, w, 4, 1'b1,
             32'h8003_0001, 32'h0000_0003);
    log_en = 1'b0;
    chk("wrap_addr_count", 32'(addr_log.size()), 32'd5);
    if (addr_log.size() >= 4) begin
      chk("wrap_addr0", {16'd0, addr_log[0]}, 32'h0000_FFFE);
      chk("wrap_addr1", {16'd0, addr_log[1]}, 32'h0000_FFFF);
      chk("wrap_addr2", {16'd0, addr_log[2]}, 32'h0000_0000);
      chk("wrap_addr3", {16'd0, addr_log[3]}, 32'h0000_0001);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_poke_ignored_done", {31'd0, done4}, 32'd1);

    // Abort mid-scan: no writes are queued, so any write is flagged by the monitor.
    wr_log = {};
    for (int i = 0; i < 16; i++) mem[16'h1000 + 16'(i)] = w1[i];
    @(negedge clk);
    hash_in_addr = 16'h1000;
    result_addr  = 16'h4050;
    target       = 32'h3000_0000;
    start16      = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_abort_busy", {31'd0, done16}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_we", {31'd0, we16}, 32'd0);
    chk("abort_done", {31'd0, done16}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_release_idle", {31'd0, done16}, 32'd1);
    chk("abort_no_writes", 32'(wr_log.size()), 32'd0);

    run_scan("after_abort", 1'b0, 16'h1000, 16'h4060, 32'h3000_0000, w1, 16, 1'b0,
             32'h8002_0E0F, 32'h1000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
